// File: rtl/branch_predict_unit_pkg.sv
// Shared constants and saturating counter helpers for the branch predictor.
// Counter helpers work on a 4-bit container; callers zero-extend and truncate.
package branch_predict_unit_pkg;
  localparam int BP_MODE_BIMODAL = 0;
  localparam int BP_MODE_GSHARE  = 1;
  localparam int BP_PC_INC       = 2;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] max);
    return (v >= max) ? v : v + 4'd1;
  endfunction

  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    return (v == 4'd0) ? v : v - 4'd1;
  endfunction
endpackage

// File: rtl/branch_predict_unit_bp_sat_counter.sv
// Next-state logic for one direction counter: allocate to weakly taken,
// otherwise saturate toward the resolved direction on a tag hit.
module bp_sat_counter
  import branch_predict_unit_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_q,
  input  logic             upd_hit,
  input  logic             alloc,
  input  logic             taken,
  output logic [CTR_W-1:0] ctr_d
);
  localparam logic [3:0]       CTR_MAX    = 4'((1 << CTR_W) - 1);
  localparam logic [CTR_W-1:0] CTR_WEAK_T = CTR_W'(1 << (CTR_W - 1));

  always_comb begin
    ctr_d = ctr_q;
    if (alloc) ctr_d = CTR_WEAK_T;
    else if (upd_hit)
      ctr_d = taken ? CTR_W'(sat_inc(4'(ctr_q), CTR_MAX)) : CTR_W'(sat_dec(4'(ctr_q)));
  end
endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal/gshare direction predictor with a direct-mapped BTB, queried
// combinationally at fetch and trained non-speculatively at resolve.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int MODE    = 0,
  parameter int GHR_W   = 4,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_next_pc,
  output logic [GHR_W-1:0]  pred_ghr,
  input  logic              lookup_en,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [GHR_W-1:0]  upd_ghr,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispred,
  input  logic              flush_all,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_mispred
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 1;
  localparam int TGT_W = ADDR_W - 1;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'((1 << (CTR_W - 1)) - 1);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [TGT_W-1:0] tgt;
  } entry_t;

  entry_t [ENTRIES-1:0]            ent_q, ent_d;
  logic   [ENTRIES-1:0][CTR_W-1:0] ctr_q, ctr_d;
  logic   [ENTRIES-1:0]            hit_vec, alloc_vec;
  logic   [GHR_W-1:0]              ghr_q, ghr_d;
  logic   [STAT_W-1:0]             stat_lookups_q, stat_lookups_d;
  logic   [STAT_W-1:0]             stat_mispred_q, stat_mispred_d;
  logic   [IDX_W-1:0]              lk_idx, up_idx;
  entry_t                          lk_ent;
  logic                            up_hit, up_go;
  logic                            unused_lsb;

  function automatic logic [IDX_W-1:0] bp_idx(input logic [ADDR_W-1:0] pc,
                                              input logic [GHR_W-1:0] ghr);
    logic [IDX_W-1:0] hist;
    hist = (MODE == BP_MODE_GSHARE) ? IDX_W'(ghr) : '0;
    return pc[IDX_W:1] ^ hist;
  endfunction

  assign unused_lsb = ^{upd_pc[0], upd_target[0]};

  // Lookup reads only state flops, so a same-cycle update is never bypassed.
  always_comb begin
    lk_idx       = bp_idx(lookup_pc, ghr_q);
    lk_ent       = ent_q[lk_idx];
    pred_hit     = lk_ent.valid && (lk_ent.tag == lookup_pc[ADDR_W-1:IDX_W+1]);
    pred_taken   = pred_hit && ctr_q[lk_idx][CTR_W-1];
    pred_next_pc = pred_taken ? {lk_ent.tgt, 1'b0} : lookup_pc + ADDR_W'(BP_PC_INC);
    pred_ghr     = ghr_q;
  end

  // A flush suppresses the whole update, so nothing is allocated behind it.
  always_comb begin
    up_idx    = bp_idx(upd_pc, upd_ghr);
    up_hit    = ent_q[up_idx].valid && (ent_q[up_idx].tag == upd_pc[ADDR_W-1:IDX_W+1]);
    up_go     = upd_valid && !flush_all;
    hit_vec   = '0;
    alloc_vec = '0;
    ent_d     = ent_q;
    for (int e = 0; e < ENTRIES; e++) begin
      if (up_idx == IDX_W'(e)) begin
        hit_vec[e]   = up_go && up_hit;
        alloc_vec[e] = up_go && !up_hit && upd_taken;
      end
      if (flush_all) ent_d[e].valid = 1'b0;
      if (alloc_vec[e]) begin
        ent_d[e].valid = 1'b1;
        ent_d[e].tag   = upd_pc[ADDR_W-1:IDX_W+1];
        ent_d[e].tgt   = upd_target[ADDR_W-1:1];
      end else if (hit_vec[e] && upd_taken) begin
        ent_d[e].tgt = upd_target[ADDR_W-1:1];
      end
    end
  end

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ctr
    bp_sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .ctr_q  (ctr_q[e]),
      .upd_hit(hit_vec[e]),
      .alloc  (alloc_vec[e]),
      .taken  (upd_taken),
      .ctr_d  (ctr_d[e])
    );
  end

  always_comb begin
    ghr_d = ghr_q;
    if (flush_all) ghr_d = '0;
    else if (upd_valid) ghr_d = GHR_W'({ghr_q, upd_taken});
    stat_lookups_d = stat_lookups_q;
    if (lookup_en && !(&stat_lookups_q)) stat_lookups_d = stat_lookups_q + STAT_W'(1);
    stat_mispred_d = stat_mispred_q;
    if (upd_valid && upd_mispred && !(&stat_mispred_q)) stat_mispred_d = stat_mispred_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q          <= '0;
      ctr_q          <= {ENTRIES{CTR_RST}};
      ghr_q          <= '0;
      stat_lookups_q <= '0;
      stat_mispred_q <= '0;
    end else begin
      ent_q          <= ent_d;
      ctr_q          <= ctr_d;
      ghr_q          <= ghr_d;
      stat_lookups_q <= stat_lookups_d;
      stat_mispred_q <= stat_mispred_d;
    end
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_mispred = stat_mispred_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Drives a bimodal and a gshare predictor with shared stimulus and checks
// both against an array-based model every cycle, plus literal pins.
module tb_branch_predict_unit;
  localparam int N  = 16;
  localparam int IW = 4;

  logic        clk = 1'b0;
  logic        rst, lookup_en, upd_valid, upd_taken, upd_mispred, flush_all;
  logic [15:0] lookup_pc, upd_pc, upd_target;
  logic [3:0]  upd_ghr;
  logic        d_hit [2];
  logic        d_tk  [2];
  logic [15:0] d_npc [2];
  logic [15:0] d_sl  [2];
  logic [15:0] d_sm  [2];
  logic [3:0]  d_ghr [2];

  always #5 clk = ~clk;

  branch_predict_unit #(.MODE(0)) u_bim (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .pred_hit(d_hit[0]), .pred_taken(d_tk[0]),
    .pred_next_pc(d_npc[0]), .pred_ghr(d_ghr[0]), .lookup_en(lookup_en), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispred(upd_mispred), .flush_all(flush_all), .stat_lookups(d_sl[0]), .stat_mispred(d_sm[0]));

  branch_predict_unit #(.MODE(1)) u_gsh (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .pred_hit(d_hit[1]), .pred_taken(d_tk[1]),
    .pred_next_pc(d_npc[1]), .pred_ghr(d_ghr[1]), .lookup_en(lookup_en), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispred(upd_mispred), .flush_all(flush_all), .stat_lookups(d_sl[1]), .stat_mispred(d_sm[1]));

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: one direct-mapped table per predictor mode.
  int m_valid [2][N];
  int m_tag   [2][N];
  int m_tgt   [2][N];
  int m_ctr   [2][N];
  int m_ghr   [2];
  int m_sl    [2];
  int m_sm    [2];
  bit m_init = 1'b0;

  function automatic int midx(int m, int pc, int ghr);
    return ((pc >> 1) % N) ^ ((m == 1) ? ghr : 0);
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        for (int e = 0; e < N; e++) begin
          m_valid[m][e] = 0; m_tag[m][e] = 0; m_tgt[m][e] = 0; m_ctr[m][e] = 1;
        end
        m_ghr[m] = 0; m_sl[m] = 0; m_sm[m] = 0;
      end else begin
        if (lookup_en && m_sl[m] < 65535) m_sl[m]++;
        if (upd_valid && upd_mispred && m_sm[m] < 65535) m_sm[m]++;
        if (flush_all) begin
          for (int e = 0; e < N; e++) m_valid[m][e] = 0;
          m_ghr[m] = 0;
        end else if (upd_valid) begin
          int i, t;
          i = midx(m, int'(upd_pc), int'(upd_ghr));
          t = int'(upd_pc) >> (IW + 1);
          if (m_valid[m][i] != 0 && m_tag[m][i] == t) begin
            if (upd_taken) begin
              if (m_ctr[m][i] < 3) m_ctr[m][i]++;
              m_tgt[m][i] = int'(upd_target) & 'hFFFE;
            end else if (m_ctr[m][i] > 0) m_ctr[m][i]--;
          end else if (upd_taken) begin
            m_valid[m][i] = 1; m_tag[m][i] = t;
            m_tgt[m][i] = int'(upd_target) & 'hFFFE; m_ctr[m][i] = 2;
          end
          m_ghr[m] = ((m_ghr[m] << 1) | int'(upd_taken)) % 16;
        end
      end
    end
    if (rst) m_init = 1'b1;
  end

  always @(negedge clk) begin
    if (m_init) begin
      for (int m = 0; m < 2; m++) begin
        int i, eh, et, en;
        i  = midx(m, int'(lookup_pc), m_ghr[m]);
        eh = (m_valid[m][i] != 0 && m_tag[m][i] == (int'(lookup_pc) >> (IW + 1))) ? 1 : 0;
        et = (eh != 0 && m_ctr[m][i] >= 2) ? 1 : 0;
        en = (et != 0) ? m_tgt[m][i] : (int'(lookup_pc) + 2) % 65536;
        chk($sformatf("hit%0d", m), d_hit[m], eh);
        chk($sformatf("taken%0d", m), d_tk[m], et);
        chk($sformatf("next_pc%0d", m), d_npc[m], en);
        chk($sformatf("ghr%0d", m), d_ghr[m], m_ghr[m]);
        chk($sformatf("stat_lk%0d", m), d_sl[m], m_sl[m]);
        chk($sformatf("stat_mp%0d", m), d_sm[m], m_sm[m]);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt, input int ghr);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_ghr = 4'(ghr);
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic look(input logic [15:0] pc, input string nm, input int eh);
    lookup_pc = pc;
    @(negedge clk);
    chk({nm, "_b"}, d_hit[0], eh);
    chk({nm, "_g"}, d_hit[1], eh);
    tick();
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] pool [8];
    pool = '{16'h0040, 16'h0060, 16'h0080, 16'h0042, 16'h00A0, 16'hFFFE, 16'h0062, 16'h0000};
    return ($urandom_range(0, 3) == 0) ? 16'($urandom) : pool[$urandom_range(0, 7)];
  endfunction

  initial begin
    rst = 1'b1; lookup_en = 1'b0; upd_valid = 1'b0; upd_taken = 1'b0; upd_mispred = 1'b0;
    flush_all = 1'b0; lookup_pc = 16'h0040; upd_pc = '0; upd_target = '0; upd_ghr = '0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t1_hit", d_hit[0], 0);
    chk("t1_taken", d_tk[0], 0);
    chk("t1_next", d_npc[0], 16'h0042);
    chk("t1_stat", d_sl[0], 0);
    tick();

    do_upd(16'h0040, 1'b1, 16'h0100, m_ghr[1]);
    @(negedge clk);
    chk("t2_hit", d_hit[0], 1);
    chk("t2_taken", d_tk[0], 1);
    chk("t2_next", d_npc[0], 16'h0100);
    tick();
    do_upd(16'h0040, 1'b0, 16'h0000, m_ghr[1]);
    do_upd(16'h0040, 1'b0, 16'h0000, m_ghr[1]);
    @(negedge clk);
    chk("t2n_hit", d_hit[0], 1);
    chk("t2n_taken", d_tk[0], 0);
    chk("t2n_next", d_npc[0], 16'h0042);
    tick();

    lookup_pc = 16'h0060;
    @(negedge clk);
    chk("t3_alias_hit", d_hit[0], 0);
    tick();
    do_upd(16'h0060, 1'b1, 16'h0200, m_ghr[1]);
    lookup_pc = 16'h0040;
    @(negedge clk);
    chk("t3_evicted", d_hit[0], 0);
    tick();
    lookup_pc = 16'h0060;
    @(negedge clk);
    chk("t3_new_next", d_npc[0], 16'h0200);
    tick();

    upd_valid = 1'b1; upd_pc = 16'h0060; upd_taken = 1'b0; upd_ghr = 4'(m_ghr[1]);
    @(negedge clk);
    chk("t4_old_next", d_npc[0], 16'h0200);
    tick();
    upd_valid = 1'b0;
    @(negedge clk);
    chk("t4_new_next", d_npc[0], 16'h0062);
    tick();

    flush_all = 1'b1; tick(); flush_all = 1'b0;
    lookup_pc = 16'h0080;
    for (int k = 0; k < 12; k++) do_upd(16'h0080, (k % 2) == 0, 16'h0300, m_ghr[1]);
    @(negedge clk);
    chk("t5_ghr_a", d_ghr[1], 4'hA);
    chk("t5_taken_a", d_tk[1], 1);
    chk("t5_next_a", d_npc[1], 16'h0300);
    tick();
    do_upd(16'h0080, 1'b1, 16'h0300, m_ghr[1]);
    @(negedge clk);
    chk("t5_ghr_5", d_ghr[1], 4'h5);
    chk("t5_taken_5", d_tk[1], 0);
    chk("t5_next_5", d_npc[1], 16'h0082);
    tick();

    do_upd(16'h0040, 1'b1, 16'h0100, 0);
    upd_valid = 1'b1; flush_all = 1'b1; upd_pc = 16'h00A0; upd_taken = 1'b1; upd_target = 16'h0400;
    tick();
    upd_valid = 1'b0; flush_all = 1'b0;
    look(16'h0040, "t6_f40", 0);
    look(16'h0060, "t6_f60", 0);
    look(16'h0080, "t6_f80", 0);
    look(16'h00A0, "t6_fA0", 0);
    lookup_pc = 16'hFFFE;
    @(negedge clk);
    chk("t6_ghr_clr", d_ghr[1], 0);
    chk("t6_wrap", d_npc[0], 16'h0000);
    tick();

    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 999) == 0);
      flush_all   = ($urandom_range(0, 39) == 0);
      lookup_en   = 1'($urandom);
      lookup_pc   = pick();
      upd_valid   = ($urandom_range(0, 2) != 0);
      upd_pc      = pick();
      upd_taken   = ($urandom_range(0, 2) != 0);
      upd_target  = 16'($urandom);
      upd_mispred = 1'($urandom);
      upd_ghr     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(m_ghr[1]);
      tick();
    end

    rst = 1'b1; flush_all = 1'b0; tick(); rst = 1'b0;
    lookup_en = 1'b1; upd_valid = 1'b1; upd_mispred = 1'b1;
    repeat (70000) tick();
    lookup_en = 1'b0; upd_valid = 1'b0;
    @(negedge clk);
    chk("t6_sat_lk", d_sl[0], 16'hFFFF);
    chk("t6_sat_mp", d_sm[1], 16'hFFFF);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
